// File: rtl/alu181_seq.sv
// alu181_seq: multi-cycle WIDTH-bit 74181-function ALU; optional zf/nf flags via ALU181_SEQ_FLAGS_EN.
// Latency: N = WIDTH/(4*NIB_PER_CYC) RUN cycles after accept; initiation interval N+2.
// Backpressure: result held in DONE until out_ready; in_ready low outside IDLE, requests not queued.
module alu181_seq #(
  parameter int WIDTH       = 16,
  parameter int NIB_PER_CYC = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             cin_n,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             cout_n,
  output logic             eqv,
  output logic             busy
`ifdef ALU181_SEQ_FLAGS_EN
  ,
  output logic             zf,
  output logic             nf
`endif
);

  localparam int GW = 4 * NIB_PER_CYC;
  localparam int N  = WIDTH / GW;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int IW = (WIDTH > 4) ? $clog2(WIDTH) : 2;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q, b_q;
  logic [3:0]       s_q;
  logic             m_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;

  logic [IW-1:0]    base;
  logic [GW-1:0]    a_grp, b_grp, grp_f;
  logic             grp_cn;
  logic [WIDTH-1:0] f_next;
  logic             last;

  // One 74181 slice, active-high data; returns {Cn+4 (active-low), F}.
  // Logic mode forces the internal carry term so F = ~(P ^ G).
  function automatic logic [4:0] slice181(input logic [3:0] av, input logic [3:0] bv,
                                          input logic [3:0] sv, input logic mv,
                                          input logic cn);
    logic [3:0] p, g, fo;
    logic       c;
    c = ~cn;
    for (int i = 0; i < 4; i++) begin
      p[i]  = av[i] | (bv[i] & sv[0]) | (~bv[i] & sv[1]);
      g[i]  = (av[i] & bv[i] & sv[3]) | (av[i] & ~bv[i] & sv[2]);
      fo[i] = p[i] ^ g[i] ^ (mv | c);
      c     = g[i] | (p[i] & c);
    end
    return {~c, fo};
  endfunction

  always_comb begin
    logic       cn;
    logic [4:0] r;
    base   = IW'(GW * int'(cnt_q));
    a_grp  = a_q[base +: GW];
    b_grp  = b_q[base +: GW];
    grp_f  = '0;
    cn     = carry_q;
    r      = '0;
    for (int j = 0; j < NIB_PER_CYC; j++) begin
      r              = slice181(a_grp[4*j +: 4], b_grp[4*j +: 4], s_q, m_q, cn);
      grp_f[4*j +: 4] = r[3:0];
      cn             = r[4];
    end
    grp_cn = cn;
    f_next = f;
    f_next[base +: GW] = grp_f;
    last   = (cnt_q == CW'(N - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      f         <= '0;
      cout_n    <= 1'b1;
      eqv       <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      s_q       <= '0;
      m_q       <= 1'b0;
      carry_q   <= 1'b1;
      cnt_q     <= '0;
`ifdef ALU181_SEQ_FLAGS_EN
      zf        <= 1'b0;
      nf        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            a_q      <= a;
            b_q      <= b;
            s_q      <= s;
            m_q      <= m;
            carry_q  <= cin_n;
            cnt_q    <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          f       <= f_next;
          carry_q <= grp_cn;
          cnt_q   <= cnt_q + CW'(1);
          if (last) begin
            out_valid <= 1'b1;
            cout_n    <= grp_cn;
            eqv       <= &f_next;
`ifdef ALU181_SEQ_FLAGS_EN
            zf        <= (f_next == '0);
            nf        <= f_next[WIDTH-1];
`endif
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu181_seq.sv
// Bench for alu181_seq: directed cases plus random ops on a 16x1 and a 32x4 instance,
// scored against a 74181 function-table model.
module tb_alu181_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        iv = 1'b0;
  logic        ordy = 1'b0;
  logic [31:0] a_drv = '0, b_drv = '0;
  logic [3:0]  s_drv = '0;
  logic        m_drv = 1'b0, cn_drv = 1'b1;

  logic        in_ready16, out_valid16, cout_n16, eqv16, busy16;
  logic [15:0] f16;
  logic        in_ready32, out_valid32, cout_n32, eqv32, busy32;
  logic [31:0] f32;
`ifdef ALU181_SEQ_FLAGS_EN
  logic        zf16, nf16, zf32, nf32;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu181_seq #(.WIDTH(16), .NIB_PER_CYC(1)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(iv & ~sel), .in_ready(in_ready16),
    .a(a_drv[15:0]), .b(b_drv[15:0]), .s(s_drv), .m(m_drv), .cin_n(cn_drv),
    .out_valid(out_valid16), .out_ready(ordy & ~sel), .f(f16), .cout_n(cout_n16),
    .eqv(eqv16), .busy(busy16)
`ifdef ALU181_SEQ_FLAGS_EN
    , .zf(zf16), .nf(nf16)
`endif
  );

  alu181_seq #(.WIDTH(32), .NIB_PER_CYC(4)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(iv & sel), .in_ready(in_ready32),
    .a(a_drv), .b(b_drv), .s(s_drv), .m(m_drv), .cin_n(cn_drv),
    .out_valid(out_valid32), .out_ready(ordy & sel), .f(f32), .cout_n(cout_n32),
    .eqv(eqv32), .busy(busy32)
`ifdef ALU181_SEQ_FLAGS_EN
    , .zf(zf32), .nf(nf32)
`endif
  );

  logic        o_rdy, o_valid, o_cout_n, o_eqv, o_busy;
  logic [31:0] o_f;
  assign o_rdy    = sel ? in_ready32  : in_ready16;
  assign o_valid  = sel ? out_valid32 : out_valid16;
  assign o_cout_n = sel ? cout_n32    : cout_n16;
  assign o_eqv    = sel ? eqv32       : eqv16;
  assign o_busy   = sel ? busy32      : busy16;
  assign o_f      = sel ? f32         : {16'h0, f16};
`ifdef ALU181_SEQ_FLAGS_EN
  logic o_zf, o_nf;
  assign o_zf = sel ? zf32 : zf16;
  assign o_nf = sel ? nf32 : nf16;
`endif

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // 74181 function table, active-high data. Arithmetic results are X + Y + carry,
  // with "minus 1" entries written as adding all-ones. Returns {cout_n, f}.
  function automatic logic [32:0] ref181(input logic [31:0] av, input logic [31:0] bv,
                                         input logic [3:0] sv, input logic mv,
                                         input logic cnv, input int w);
    logic [63:0] msk, x, y, sum, aa, bb, nb;
    msk = (64'd1 << w) - 64'd1;
    aa  = {32'h0, av} & msk;
    bb  = {32'h0, bv} & msk;
    nb  = ~bb & msk;
    if (mv) begin
      case (sv)
        4'h0: x = ~aa;        4'h1: x = ~(aa | bb);
        4'h2: x = ~aa & bb;   4'h3: x = 64'h0;
        4'h4: x = ~(aa & bb); 4'h5: x = ~bb;
        4'h6: x = aa ^ bb;    4'h7: x = aa & nb;
        4'h8: x = ~aa | bb;   4'h9: x = ~(aa ^ bb);
        4'hA: x = bb;         4'hB: x = aa & bb;
        4'hC: x = msk;        4'hD: x = aa | nb;
        4'hE: x = aa | bb;    default: x = aa;
      endcase
      return {1'b1, x[31:0] & msk[31:0]};
    end
    case (sv)
      4'h0: begin x = aa;          y = 64'h0;   end
      4'h1: begin x = aa | bb;     y = 64'h0;   end
      4'h2: begin x = aa | nb;     y = 64'h0;   end
      4'h3: begin x = msk;         y = 64'h0;   end
      4'h4: begin x = aa;          y = aa & nb; end
      4'h5: begin x = aa | bb;     y = aa & nb; end
      4'h6: begin x = aa;          y = nb;      end
      4'h7: begin x = aa & nb;     y = msk;     end
      4'h8: begin x = aa;          y = aa & bb; end
      4'h9: begin x = aa;          y = bb;      end
      4'hA: begin x = aa | nb;     y = aa & bb; end
      4'hB: begin x = aa & bb;     y = msk;     end
      4'hC: begin x = aa;          y = aa;      end
      4'hD: begin x = aa | bb;     y = aa;      end
      4'hE: begin x = aa | nb;     y = aa;      end
      default: begin x = aa;       y = msk;     end
    endcase
    sum = x + y + (cnv ? 64'd0 : 64'd1);
    return {~sum[w], sum[31:0] & msk[31:0]};
  endfunction

  task automatic op(input logic s32, input logic [31:0] av, input logic [31:0] bv,
                    input logic [3:0] sv, input logic mv, input logic cnv, input int stall);
    int          lat, n, w;
    logic [32:0] e;
    logic [31:0] msk;
    w   = s32 ? 32 : 16;
    n   = s32 ? 2 : 4;
    msk = s32 ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    e   = ref181(av, bv, sv, mv, cnv, w);
    sel = s32;
    #1;
    lat = 0;
    while (!o_rdy && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    chk("in_ready_idle", o_rdy, 1);
    a_drv = av; b_drv = bv; s_drv = sv; m_drv = mv; cn_drv = cnv; iv = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0;
    a_drv = $urandom; b_drv = $urandom; s_drv = 4'($urandom); m_drv = 1'($urandom);
    cn_drv = 1'($urandom);
    chk("busy_run", o_busy, 1);
    chk("in_ready_run", o_rdy, 0);
    lat = 0;
    while (!o_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    chk("latency", lat, n);
    chk("f", o_f, e[31:0]);
    if (!mv) chk("cout_n", o_cout_n, e[32]);
    chk("eqv", o_eqv, (e[31:0] == msk));
`ifdef ALU181_SEQ_FLAGS_EN
    chk("zf", o_zf, (e[31:0] == 32'h0));
    chk("nf", o_nf, s32 ? e[31] : e[15]);
`endif
    for (int i = 0; i < stall; i++) begin
      iv = 1'b1; a_drv = $urandom; s_drv = 4'($urandom);
      @(posedge clk); #1;
      chk("hold_valid", o_valid, 1);
      chk("hold_f", o_f, e[31:0]);
      chk("hold_rdy", o_rdy, 0);
    end
    iv = 1'b0; ordy = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0;
    chk("valid_drop", o_valid, 0);
    chk("idle_rdy", o_rdy, 1);
    chk("idle_busy", o_busy, 0);
  endtask

  initial begin
    logic seen;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready16, 0);
    chk("rst_out_valid", out_valid16, 0);
    chk("rst_f", f16, 16'h0);
    chk("rst_cout_n", cout_n16, 1);
    chk("rst_eqv", eqv16, 0);
    chk("rst_busy", busy16, 0);
`ifdef ALU181_SEQ_FLAGS_EN
    chk("rst_zf", zf16, 0);
    chk("rst_nf", nf16, 0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rel_in_ready", in_ready16, 1);

    op(0, 32'h1234, 32'h4321, 4'b1001, 0, 1, 0);
    op(0, 32'hFFFF, 32'h0001, 4'b1001, 0, 1, 0);
    op(0, 32'h5000, 32'h1000, 4'b0110, 0, 0, 0);
    op(0, 32'h3C3C, 32'h3C3C, 4'b0110, 0, 1, 0);
    op(0, 32'hF0F0, 32'hFF00, 4'b0110, 1, 1, 0);
    op(0, 32'h1234, 32'h0000, 4'b0000, 1, 1, 0);
    op(0, 32'hA5A5, 32'h0F0F, 4'b1001, 0, 0, 10);
    op(0, 32'h0001, 32'h0002, 4'b1001, 0, 1, 0);

    // Abort mid-RUN: reset lands in the second RUN cycle.
    sel = 1'b0;
    a_drv = 32'h1234; b_drv = 32'h4321; s_drv = 4'b1001; m_drv = 1'b0; cn_drv = 1'b1;
    iv = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("abort_valid", out_valid16, 0);
    chk("abort_f", f16, 16'h0);
    chk("abort_cout_n", cout_n16, 1);
    chk("abort_busy", busy16, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      seen = seen | out_valid16;
    end
    chk("abort_no_result", seen, 0);
    chk("abort_ready", in_ready16, 1);

    op(1, 32'h1234, 32'h4321, 4'b1001, 0, 1, 0);
    op(1, 32'hFFFF_FFFF, 32'h0000_0001, 4'b1001, 0, 1, 2);

    for (int k = 0; k < 120; k++)
      op(0, $urandom, $urandom, 4'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 2));
    for (int k = 0; k < 60; k++)
      op(1, $urandom, $urandom, 4'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 2));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
